// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, operand select and load-use stall
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    // decoded instruction from ID
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm32,
    input  logic [4:0]  id_shamt,
    input  logic        id_alusrc_a,
    input  logic        id_alusrc_b,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic [4:0]  id_dst,
    // pipeline control
    input  logic        flush,
    input  logic        hold,
    // forwarding sources
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_dst,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_dst,
    input  logic [31:0] memwb_result,
    // outputs
    output logic        stall,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_sign,
    output logic [5:0]  alu_fun,
    output logic [31:0] ex_store_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_dst
);

    // registered state
    logic        valid_q,     valid_d;
    logic [4:0]  rs_addr_q,   rs_addr_d;
    logic [4:0]  rt_addr_q,   rt_addr_d;
    logic        uses_rs_q,   uses_rs_d;
    logic        uses_rt_q,   uses_rt_d;
    logic [31:0] rs_data_q,   rs_data_d;
    logic [31:0] rt_data_q,   rt_data_d;
    logic [31:0] imm32_q,     imm32_d;
    logic [4:0]  shamt_q,     shamt_d;
    logic        alusrc_a_q,  alusrc_a_d;
    logic        alusrc_b_q,  alusrc_b_d;
    logic [5:0]  alufun_q,    alufun_d;
    logic        sign_q,      sign_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [4:0]  dst_q,       dst_d;

    logic        load_use;
    logic        rs_hit;
    logic        rt_hit;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Load-use: the load in EX has no data until MEM, so a dependent ID instruction must wait one cycle
    always_comb begin
        rs_hit   = id_uses_rs && (id_rs_addr == dst_q);
        rt_hit   = id_uses_rt && (id_rt_addr == dst_q);
        load_use = valid_q && mem_read_q && (dst_q != 5'd0) && (rs_hit || rt_hit);
        stall    = hold || (load_use && id_valid);
    end

    // Next-state select: flush beats hold, hold beats load-use bubble, otherwise capture ID
    always_comb begin
        valid_d     = valid_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        uses_rs_d   = uses_rs_q;
        uses_rt_d   = uses_rt_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm32_d     = imm32_q;
        shamt_d     = shamt_q;
        alusrc_a_d  = alusrc_a_q;
        alusrc_b_d  = alusrc_b_q;
        alufun_d    = alufun_q;
        sign_d      = sign_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        dst_d       = dst_q;

        if (flush || (!hold && (load_use || !id_valid))) begin
            // bubble: all-zero fields make the ALU compute 0+0 with no side effects
            valid_d     = 1'b0;
            rs_addr_d   = 5'd0;
            rt_addr_d   = 5'd0;
            uses_rs_d   = 1'b0;
            uses_rt_d   = 1'b0;
            rs_data_d   = 32'd0;
            rt_data_d   = 32'd0;
            imm32_d     = 32'd0;
            shamt_d     = 5'd0;
            alusrc_a_d  = 1'b0;
            alusrc_b_d  = 1'b0;
            alufun_d    = 6'd0;
            sign_d      = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            dst_d       = 5'd0;
        end else if (!hold) begin
            valid_d     = 1'b1;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            uses_rs_d   = id_uses_rs;
            uses_rt_d   = id_uses_rt;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm32_d     = id_imm32;
            shamt_d     = id_shamt;
            alusrc_a_d  = id_alusrc_a;
            alusrc_b_d  = id_alusrc_b;
            alufun_d    = id_alufun;
            sign_d      = id_sign;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            dst_d       = id_dst;
        end
    end

    // Pipeline register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            uses_rs_q   <= 1'b0;
            uses_rt_q   <= 1'b0;
            rs_data_q   <= 32'd0;
            rt_data_q   <= 32'd0;
            imm32_q     <= 32'd0;
            shamt_q     <= 5'd0;
            alusrc_a_q  <= 1'b0;
            alusrc_b_q  <= 1'b0;
            alufun_q    <= 6'd0;
            sign_q      <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            dst_q       <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            uses_rs_q   <= uses_rs_d;
            uses_rt_q   <= uses_rt_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm32_q     <= imm32_d;
            shamt_q     <= shamt_d;
            alusrc_a_q  <= alusrc_a_d;
            alusrc_b_q  <= alusrc_b_d;
            alufun_q    <= alufun_d;
            sign_q      <= sign_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            dst_q       <= dst_d;
        end
    end

    // Forwarding: youngest producer (EX/MEM) wins; $0 is never forwarded
    always_comb begin
        if (exmem_reg_write && (exmem_dst != 5'd0) && (exmem_dst == rs_addr_q)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_dst != 5'd0) && (memwb_dst == rs_addr_q)) begin
            fwd_rs = memwb_result;
        end else begin
            fwd_rs = rs_data_q;
        end

        if (exmem_reg_write && (exmem_dst != 5'd0) && (exmem_dst == rt_addr_q)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_dst != 5'd0) && (memwb_dst == rt_addr_q)) begin
            fwd_rt = memwb_result;
        end else begin
            fwd_rt = rt_data_q;
        end
    end

    // Operand selection and registered control outputs
    always_comb begin
        alu_a         = alusrc_a_q ? {27'd0, shamt_q} : fwd_rs;
        alu_b         = alusrc_b_q ? imm32_q : fwd_rt;
        ex_store_data = fwd_rt;
        alu_fun       = alufun_q;
        alu_sign      = sign_q;
        ex_valid      = valid_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_dst        = dst_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm32;
    logic [4:0]  id_shamt;
    logic        id_alusrc_a, id_alusrc_b;
    logic [5:0]  id_alufun;
    logic        id_sign, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  id_dst;
    logic        flush, hold;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_result, memwb_result;
    logic        stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic        alu_sign;
    logic [5:0]  alu_fun;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_dst;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32),
        .id_shamt(id_shamt), .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_dst(id_dst),
        .flush(flush), .hold(hold),
        .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_result(memwb_result),
        .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_sign(alu_sign), .alu_fun(alu_fun),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_dst(ex_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; id_shamt = 0;
        id_alusrc_a = 0; id_alusrc_b = 0; id_alufun = 0; id_sign = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_dst = 0;
        flush = 0; hold = 0;
        exmem_reg_write = 0; exmem_dst = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dst = 0; memwb_result = 0;
    endtask

    task automatic load_alu_instr(input logic [4:0] rs, input logic [31:0] rsd,
                                  input logic [4:0] rt, input logic [31:0] rtd,
                                  input logic [4:0] dst);
        id_valid = 1; id_rs_addr = rs; id_rs_data = rsd; id_uses_rs = 1;
        id_rt_addr = rt; id_rt_data = rtd; id_uses_rt = 1;
        id_dst = dst; id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
        id_alusrc_a = 0; id_alusrc_b = 0; id_alufun = 0; id_sign = 0;
        id_imm32 = 0; id_shamt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        load_alu_instr(5'd8, 32'h5, 5'd9, 32'h7, 5'd10);
        reset = 1;
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %h exp 0", ex_valid); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || ex_store_data !== 32'd0) begin errors++; $display("FAIL reset_operands got %h %h %h exp 0", alu_a, alu_b, ex_store_data); end
        checks++; if (ex_dst !== 5'd0 || ex_reg_write !== 1'b0 || alu_fun !== 6'd0 || alu_sign !== 1'b0) begin errors++; $display("FAIL reset_ctrl got dst %h rw %h fun %h sign %h exp 0", ex_dst, ex_reg_write, alu_fun, alu_sign); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %h exp 0", stall); end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_capture();
        load_alu_instr(5'd8, 32'h5, 5'd9, 32'h7, 5'd10);
        step();
        idle_inputs();
        #1;
        checks++; if (alu_a !== 32'h5) begin errors++; $display("FAIL capture_a got %h exp 5", alu_a); end
        checks++; if (alu_b !== 32'h7) begin errors++; $display("FAIL capture_b got %h exp 7", alu_b); end
        checks++; if (ex_valid !== 1'b1 || ex_dst !== 5'd10 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL capture_ctrl got v %h dst %h rw %h exp 1 0a 1", ex_valid, ex_dst, ex_reg_write); end
        checks++; if (ex_store_data !== 32'h7) begin errors++; $display("FAIL capture_store got %h exp 7", ex_store_data); end
    endtask

    task automatic test_invalid_bubble();
        load_alu_instr(5'd8, 32'h5, 5'd9, 32'h7, 5'd10);
        id_valid = 0;
        step();
        checks++; if (ex_valid !== 1'b0 || alu_a !== 32'd0 || ex_dst !== 5'd0) begin errors++; $display("FAIL invalid_bubble got v %h a %h dst %h exp 0", ex_valid, alu_a, ex_dst); end
        idle_inputs();
    endtask

    task automatic test_forward();
        load_alu_instr(5'd8, 32'h1, 5'd9, 32'h2, 5'd3);
        step();
        idle_inputs();
        exmem_reg_write = 1; exmem_dst = 5'd8; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_dst = 5'd8; memwb_result = 32'h22;
        #1;
        checks++; if (alu_a !== 32'h11) begin errors++; $display("FAIL fwd_exmem_prio got %h exp 11", alu_a); end
        exmem_dst = 5'd0;
        #1;
        checks++; if (alu_a !== 32'h22) begin errors++; $display("FAIL fwd_memwb got %h exp 22", alu_a); end
        memwb_dst = 5'd0;
        #1;
        checks++; if (alu_a !== 32'h1) begin errors++; $display("FAIL fwd_none got %h exp 1", alu_a); end
        exmem_dst = 5'd9;
        #1;
        checks++; if (alu_b !== 32'h11 || ex_store_data !== 32'h11 || alu_a !== 32'h1) begin errors++; $display("FAIL fwd_rt got b %h st %h a %h exp 11 11 1", alu_b, ex_store_data, alu_a); end
        exmem_reg_write = 0;
        #1;
        checks++; if (alu_b !== 32'h2) begin errors++; $display("FAIL fwd_no_write got %h exp 2", alu_b); end
        idle_inputs();
        load_alu_instr(5'd0, 32'h33, 5'd0, 32'h44, 5'd4);
        step();
        idle_inputs();
        exmem_reg_write = 1; exmem_dst = 5'd0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_dst = 5'd0; memwb_result = 32'h22;
        #1;
        checks++; if (alu_a !== 32'h33 || alu_b !== 32'h44) begin errors++; $display("FAIL fwd_reg0 got a %h b %h exp 33 44", alu_a, alu_b); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1; id_rs_addr = 5'd29; id_rs_data = 32'h100; id_uses_rs = 1;
        id_imm32 = 32'h4; id_alusrc_b = 1; id_mem_read = 1; id_reg_write = 1; id_dst = 5'd8;
        step();
        idle_inputs();
        load_alu_instr(5'd8, 32'hDEAD, 5'd9, 32'h3, 5'd11);
        id_uses_rs = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused_rs got stall %h exp 0", stall); end
        id_uses_rs = 1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || alu_a !== 32'd0 || stall !== 1'b0) begin errors++; $display("FAIL lu_bubble got v %h a %h stall %h exp 0 0 0", ex_valid, alu_a, stall); end
        step();
        memwb_reg_write = 1; memwb_dst = 5'd8; memwb_result = 32'hABCD;
        #1;
        checks++; if (alu_a !== 32'hABCD || ex_valid !== 1'b1 || alu_b !== 32'h3 || ex_dst !== 5'd11) begin errors++; $display("FAIL lu_forward got a %h v %h b %h dst %h exp abcd 1 3 0b", alu_a, ex_valid, alu_b, ex_dst); end
        idle_inputs();
    endtask

    task automatic test_flush_load_use();
        idle_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_dst = 5'd7;
        step();
        load_alu_instr(5'd1, 32'h1, 5'd7, 32'h2, 5'd12);
        flush = 1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_lu_stall got %h exp 1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_dst !== 5'd0) begin errors++; $display("FAIL flush_lu_bubble got v %h dst %h exp 0 0", ex_valid, ex_dst); end
        idle_inputs();
    endtask

    task automatic test_shift_imm();
        load_alu_instr(5'd5, 32'h999, 5'd9, 32'hF0, 5'd6);
        id_alusrc_a = 1; id_shamt = 5'd4; id_alufun = 6'h20; id_sign = 1;
        step();
        checks++; if (alu_a !== 32'h4 || alu_b !== 32'hF0) begin errors++; $display("FAIL shift_ops got a %h b %h exp 4 f0", alu_a, alu_b); end
        checks++; if (alu_fun !== 6'h20 || alu_sign !== 1'b1) begin errors++; $display("FAIL shift_ctrl got fun %h sign %h exp 20 1", alu_fun, alu_sign); end
        load_alu_instr(5'd5, 32'h77, 5'd9, 32'h1234, 5'd6);
        id_alusrc_b = 1; id_imm32 = 32'hFFFFFFFF; id_mem_write = 1;
        step();
        checks++; if (alu_b !== 32'hFFFFFFFF || ex_store_data !== 32'h1234 || alu_a !== 32'h77) begin errors++; $display("FAIL imm_ops got a %h b %h st %h exp 77 ffffffff 1234", alu_a, alu_b, ex_store_data); end
        checks++; if (ex_mem_write !== 1'b1 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL imm_ctrl got mw %h mr %h exp 1 0", ex_mem_write, ex_mem_read); end
        idle_inputs();
    endtask

    task automatic test_flush_hold();
        load_alu_instr(5'd2, 32'hAA, 5'd3, 32'hBB, 5'd13);
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fh_pre got %h exp 1", ex_valid); end
        load_alu_instr(5'd4, 32'hCC, 5'd5, 32'hDD, 5'd14);
        flush = 1; hold = 1;
        step();
        checks++; if (ex_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || ex_dst !== 5'd0) begin errors++; $display("FAIL flush_hold got v %h a %h b %h dst %h exp 0", ex_valid, alu_a, alu_b, ex_dst); end
        idle_inputs();
    endtask

    task automatic test_hold();
        load_alu_instr(5'd2, 32'h55, 5'd3, 32'h66, 5'd12);
        step();
        load_alu_instr(5'd4, 32'h99, 5'd5, 32'h88, 5'd15);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got %h exp 1", i, stall); end
            step();
            checks++; if (alu_a !== 32'h55 || alu_b !== 32'h66 || ex_dst !== 5'd12 || ex_valid !== 1'b1) begin errors++; $display("FAIL hold_keep[%0d] got a %h b %h dst %h v %h exp 55 66 0c 1", i, alu_a, alu_b, ex_dst, ex_valid); end
        end
        exmem_reg_write = 1; exmem_dst = 5'd2; exmem_result = 32'h1234;
        #1;
        checks++; if (alu_a !== 32'h1234) begin errors++; $display("FAIL hold_fwd got %h exp 1234", alu_a); end
        exmem_reg_write = 0;
        hold = 0;
        step();
        checks++; if (alu_a !== 32'h99 || ex_dst !== 5'd15) begin errors++; $display("FAIL hold_release got a %h dst %h exp 99 0f", alu_a, ex_dst); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_hold();
        load_alu_instr(5'd2, 32'h55, 5'd3, 32'h66, 5'd12);
        step();
        hold = 1; reset = 1;
        step();
        reset = 0;
        checks++; if (ex_valid !== 1'b0 || alu_a !== 32'd0 || ex_dst !== 5'd0) begin errors++; $display("FAIL reset_hold got v %h a %h dst %h exp 0", ex_valid, alu_a, ex_dst); end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_capture();
        test_invalid_bubble();
        test_forward();
        test_load_use();
        test_flush_load_use();
        test_shift_imm();
        test_flush_hold();
        test_hold();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
